// File: rtl/wb_sram_arbiter.sv
// Round-robin arbiter sharing one Wishbone SRAM slave between two masters.
// Grants last for a whole CYC burst; a per-access watchdog answers a silent slave with ERR.
module wb_sram_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rstn,

    input  logic [ADDR_WIDTH-1:0]   m0_adr,
    input  logic [DATA_WIDTH-1:0]   m0_dat_w,
    output logic [DATA_WIDTH-1:0]   m0_dat_r,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    output logic                    m0_ack,
    output logic                    m0_err,

    input  logic [ADDR_WIDTH-1:0]   m1_adr,
    input  logic [DATA_WIDTH-1:0]   m1_dat_w,
    output logic [DATA_WIDTH-1:0]   m1_dat_r,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    output logic                    m1_ack,
    output logic                    m1_err,

    output logic [ADDR_WIDTH-1:0]   s_adr,
    output logic [DATA_WIDTH-1:0]   s_dat_w,
    input  logic [DATA_WIDTH-1:0]   s_dat_r,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    input  logic                    s_ack,

    output logic [1:0]              grant,
    output logic                    last_owner
);

    localparam int                SEL_W   = DATA_WIDTH / 8;
    localparam int                WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_MAX  = '1;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd;
    logic            err_q;

    logic [ADDR_WIDTH-1:0] o_adr;
    logic [DATA_WIDTH-1:0] o_dat_w;
    logic [SEL_W-1:0]      o_sel;
    logic                  o_cyc;
    logic                  o_stb;
    logic                  o_we;

    always_comb begin
        if (grant[1]) begin
            o_adr   = m1_adr;
            o_dat_w = m1_dat_w;
            o_sel   = m1_sel;
            o_cyc   = m1_cyc;
            o_stb   = m1_stb;
            o_we    = m1_we;
        end else begin
            o_adr   = m0_adr;
            o_dat_w = m0_dat_w;
            o_sel   = m0_sel;
            o_cyc   = m0_cyc;
            o_stb   = m0_stb;
            o_we    = m0_we;
        end
    end

    // The error cycle withdraws the strobe so the slave cannot ack alongside ERR.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        if (state == OWNED) begin
            s_adr   = o_adr;
            s_dat_w = o_dat_w;
            s_sel   = o_sel;
            s_cyc   = o_cyc & ~err_q;
            s_stb   = o_stb & ~err_q;
            s_we    = o_we;
        end
    end

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;
    assign m0_ack   = grant[0] & s_ack & ~err_q;
    assign m1_ack   = grant[1] & s_ack & ~err_q;
    assign m0_err   = grant[0] & err_q;
    assign m1_err   = grant[1] & err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;
            wd         <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wd    <= '0;
                    err_q <= 1'b0;
                    if (m0_cyc && m1_cyc) begin
                        grant <= last_owner ? 2'b01 : 2'b10;
                        state <= OWNED;
                    end else if (m0_cyc) begin
                        grant <= 2'b01;
                        state <= OWNED;
                    end else if (m1_cyc) begin
                        grant <= 2'b10;
                        state <= OWNED;
                    end
                end
                OWNED: begin
                    if (!o_cyc) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_owner <= grant[1];
                        wd         <= '0;
                        err_q      <= 1'b0;
                    end else if (err_q) begin
                        err_q <= 1'b0;
                        wd    <= '0;
                    end else if (o_stb && !s_ack) begin
                        // ACK on the threshold cycle takes the else branch, so ACK beats ERR.
                        if (wd == WD_LAST) begin
                            err_q <= 1'b1;
                            wd    <= '0;
                        end else if (wd != WD_MAX) begin
                            wd <= wd + 1'b1;
                        end
                    end else begin
                        wd <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Bench for wb_sram_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a cycle-level reference model of ownership and stall counting.
module tb_wb_sram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0]    mcyc, mstb, mwe;
    logic [AW-1:0] madr [2];
    logic [DW-1:0] mdatw [2];
    logic [SW-1:0] msel [2];
    logic [DW-1:0] m0_dat_r, m1_dat_r;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w, s_dat_r;
    logic [SW-1:0] s_sel;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [1:0]    grant;
    logic          last_owner;
    logic          ack_en;

    int total = 0;
    int bad   = 0;

    wb_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn),
        .m0_adr(madr[0]), .m0_dat_w(mdatw[0]), .m0_dat_r(m0_dat_r), .m0_sel(msel[0]),
        .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(madr[1]), .m1_dat_w(mdatw[1]), .m1_dat_r(m1_dat_r), .m1_sel(msel[1]),
        .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack),
        .grant(grant), .last_owner(last_owner)
    );

    // SRAM slave: acks in the strobed cycle when enabled, word-indexed by adr[5:2].
    logic [DW-1:0] smem [16];
    assign s_ack   = ack_en & s_stb;
    assign s_dat_r = smem[s_adr[5:2]];
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) smem[i] <= '0;
        end else if (s_cyc && s_stb && s_we && s_ack) begin
            for (int b = 0; b < SW; b++)
                if (s_sel[b]) smem[s_adr[5:2]][8*b +: 8] <= s_dat_w[8*b +: 8];
        end
    end

    // Reference model: owner index (-1 = nobody), last owner, and the number of
    // consecutive strobe cycles the owner has waited without ACK.
    int            own   = -1;
    int            lst   = 1;
    int            stall = 0;
    bit            mv    = 1'b0;
    logic [DW-1:0] mmem [16];

    logic          o, errc, e_stall;
    logic [1:0]    e_grant, e_ack, e_err;
    logic          e_scyc, e_sstb, e_swe, e_sack;
    logic [AW-1:0] e_sadr;
    logic [DW-1:0] e_sdatw, e_datr;
    logic [SW-1:0] e_ssel;

    always_comb begin
        o       = 1'b0;
        errc    = 1'b0;
        e_grant = 2'b00;
        e_ack   = 2'b00;
        e_err   = 2'b00;
        e_scyc  = 1'b0;
        e_sstb  = 1'b0;
        e_swe   = 1'b0;
        e_sadr  = '0;
        e_sdatw = '0;
        e_ssel  = '0;
        if (own >= 0) begin
            o          = own[0];
            errc       = (stall == TO);
            e_grant[o] = 1'b1;
            e_sadr     = madr[o];
            e_sdatw    = mdatw[o];
            e_ssel     = msel[o];
            e_swe      = mwe[o];
            e_scyc     = mcyc[o] && !errc;
            e_sstb     = mstb[o] && !errc;
        end
        e_sack  = ack_en && e_sstb;
        e_stall = (own >= 0) && !errc && mstb[o] && !e_sack;
        if (own >= 0) begin
            e_ack[o] = e_sack && !errc;
            e_err[o] = errc;
        end
        e_datr = mmem[e_sadr[5:2]];
    end

    always @(posedge clk) begin
        if (!rstn) begin
            own   <= -1;
            lst   <= 1;
            stall <= 0;
            mv    <= 1'b1;
            for (int i = 0; i < 16; i++) mmem[i] <= '0;
        end else begin
            if (e_scyc && e_sstb && e_swe && e_sack)
                for (int b = 0; b < SW; b++)
                    if (e_ssel[b]) mmem[e_sadr[5:2]][8*b +: 8] <= e_sdatw[8*b +: 8];
            if (own < 0) begin
                stall <= 0;
                if (mcyc == 2'b11) own <= 1 - lst;
                else if (mcyc[0])  own <= 0;
                else if (mcyc[1])  own <= 1;
            end else if (!mcyc[o]) begin
                lst   <= own;
                own   <= -1;
                stall <= 0;
            end else if (e_stall) begin
                stall <= stall + 1;
            end else begin
                stall <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mv) begin
            chk("grant",      64'(grant),      64'(e_grant));
            chk("last_owner", 64'(last_owner), 64'(lst[0]));
            chk("s_cyc",      64'(s_cyc),      64'(e_scyc));
            chk("s_stb",      64'(s_stb),      64'(e_sstb));
            chk("s_we",       64'(s_we),       64'(e_swe));
            chk("s_adr",      64'(s_adr),      64'(e_sadr));
            chk("s_dat_w",    64'(s_dat_w),    64'(e_sdatw));
            chk("s_sel",      64'(s_sel),      64'(e_ssel));
            chk("ack",        64'({m1_ack, m0_ack}), 64'(e_ack));
            chk("err",        64'({m1_err, m0_err}), 64'(e_err));
            chk("m0_dat_r",   64'(m0_dat_r),   64'(e_datr));
            chk("m1_dat_r",   64'(m1_dat_r),   64'(e_datr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        mcyc = 2'b00;
        mstb = 2'b00;
        mwe  = 2'b00;
        step();
        rstn = 1'b1;
    endtask

    int cnt0, cnt1, errs, sup;

    initial begin
        rstn   = 1'b0;
        mcyc   = 2'b00;
        mstb   = 2'b00;
        mwe    = 2'b00;
        ack_en = 1'b1;
        for (int m = 0; m < 2; m++) begin
            madr[m]  = '0;
            mdatw[m] = '0;
            msel[m]  = '0;
        end
        step();
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'(2'b00));
        chk("rst_last",  64'(last_owner), 64'(1'b1));
        chk("rst_scyc",  64'(s_cyc), 64'(1'b0));
        chk("rst_ackerr", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'(4'b0000));

        // Single master: write then read back.
        step();
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b1;
        madr[0] = 32'h10; mdatw[0] = 32'hDEADBEEF; msel[0] = 4'hF;
        @(negedge clk);
        chk("sm_idle_grant", 64'(grant), 64'(2'b00));
        step();
        @(negedge clk);
        chk("sm_grant",  64'(grant), 64'(2'b01));
        chk("sm_wr_ack", 64'(m0_ack), 64'(1'b1));
        step();
        mwe[0] = 1'b0;
        @(negedge clk);
        chk("sm_rd_ack",  64'(m0_ack), 64'(1'b1));
        chk("sm_rd_data", 64'(m0_dat_r), 64'(32'hDEADBEEF));
        chk("sm_m1_ack",  64'(m1_ack), 64'(1'b0));
        step();
        mcyc[0] = 1'b0; mstb[0] = 1'b0;

        // Contention straight after reset.
        do_reset();
        mcyc = 2'b11;
        step();
        @(negedge clk);
        chk("ct_first", 64'(grant), 64'(2'b01));
        step();
        mcyc[0] = 1'b0;
        step();
        @(negedge clk);
        chk("ct_gap", 64'(grant), 64'(2'b00));
        step();
        @(negedge clk);
        chk("ct_second", 64'(grant), 64'(2'b10));
        step();
        mcyc = 2'b00;

        // Round-robin: both always requesting, single-access bursts.
        do_reset();
        mcyc = 2'b11;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            mstb[k % 2] = 1'b1;
            @(negedge clk);
            chk("rr_grant", 64'(grant), (k % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
            cnt0 += int'(m0_ack);
            cnt1 += int'(m1_ack);
            step();
            mstb[k % 2] = 1'b0;
            mcyc[k % 2] = 1'b0;
            step();
            mcyc[k % 2] = 1'b1;
            @(negedge clk);
            chk("rr_gap", 64'(grant), 64'(2'b00));
        end
        chk("rr_cnt0", 64'(cnt0), 64'(4));
        chk("rr_cnt1", 64'(cnt1), 64'(4));
        mcyc = 2'b00;

        // Burst hold: m1 keeps cyc for 4 accesses while m0 waits.
        do_reset();
        mcyc[1] = 1'b1;
        step();
        mcyc[0] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1; madr[1] = 32'h20;
        mdatw[1] = 32'h0BADF00D; msel[1] = 4'hF;
        cnt1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bh_grant", 64'(grant), 64'(2'b10));
            cnt1 += int'(m1_ack);
            step();
            madr[1] = 32'h24 + 32'(4 * i);
        end
        chk("bh_acks", 64'(cnt1), 64'(4));
        mstb[1] = 1'b0; mcyc[1] = 1'b0;
        step();
        @(negedge clk);
        chk("bh_gap", 64'(grant), 64'(2'b00));
        step();
        @(negedge clk);
        chk("bh_m0", 64'(grant), 64'(2'b01));
        step();
        mcyc = 2'b00; mstb = 2'b00;

        // Timeout with ACK suppressed, then ACK exactly on the threshold cycle.
        do_reset();
        mcyc[0] = 1'b1; mstb[0] = 1'b1; ack_en = 1'b0;
        errs = 0;
        for (int n = 0; n <= 16; n++) begin
            step();
            @(negedge clk);
            if (n == 0) chk("to_first_stb", 64'(s_stb), 64'(1'b1));
            if (m0_err) errs++;
            if (n == 16) begin
                chk("to_err",     64'(m0_err), 64'(1'b1));
                chk("to_err_stb", 64'(s_stb),  64'(1'b0));
                chk("to_err_ack", 64'(m0_ack), 64'(1'b0));
            end
        end
        step();
        mcyc[0] = 1'b0; mstb[0] = 1'b0; mcyc[1] = 1'b1; mstb[1] = 1'b1;
        @(negedge clk);
        chk("to_err_width", 64'(m0_err), 64'(1'b0));
        chk("to_err_count", 64'(errs), 64'(1));
        step();
        @(negedge clk);
        chk("to_gap", 64'(grant), 64'(2'b00));
        step();
        @(negedge clk);
        chk("to_m1_grant", 64'(grant), 64'(2'b10));
        for (int n = 1; n <= 15; n++) begin
            step();
            if (n == 15) ack_en = 1'b1;
            @(negedge clk);
            if (n == 15) chk("aw_ack", 64'(m1_ack), 64'(1'b1));
        end
        step();
        mstb[1] = 1'b0;
        @(negedge clk);
        chk("aw_no_err", 64'(m1_err), 64'(1'b0));
        step();
        mcyc = 2'b00;

        // Reset while m1 owns the bus.
        do_reset();
        mcyc[1] = 1'b1; mstb[1] = 1'b1;
        step();
        @(negedge clk);
        chk("rb_owner", 64'(grant), 64'(2'b10));
        step();
        rstn = 1'b0; mcyc[0] = 1'b1;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("rb_grant", 64'(grant), 64'(2'b00));
        chk("rb_scyc",  64'(s_cyc), 64'(1'b0));
        chk("rb_last",  64'(last_owner), 64'(1'b1));
        step();
        @(negedge clk);
        chk("rb_m0_first", 64'(grant), 64'(2'b01));
        step();
        mcyc = 2'b00; mstb = 2'b00;

        // Randomized traffic, with occasional ACK blackouts and resets.
        sup = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            rstn = ($urandom_range(0, 599) != 0);
            for (int m = 0; m < 2; m++) begin
                if (mcyc[m]) begin
                    if ($urandom_range(0, (sup > 0) ? 63 : 7) == 0) mcyc[m] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    mcyc[m] = 1'b1;
                end
                mstb[m]  = (sup > 0) || ($urandom_range(0, 3) != 0);
                mwe[m]   = 1'($urandom_range(0, 1));
                madr[m]  = $urandom;
                mdatw[m] = $urandom;
                msel[m]  = 4'($urandom_range(0, 15));
            end
            if (sup > 0) begin
                ack_en = 1'b0;
                sup--;
            end else begin
                ack_en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 99) == 0) sup = 40;
            end
        end
        step();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sram_arbiter.md
Name: wb_sram_arbiter

Overview:
Two-master Wishbone arbiter that shares one Wishbone SRAM slave between two requesters, e.g. a CPU data port and a DMA engine in a BFM testbench. Grants are round-robin. A grant is held for the whole CYC burst. A per-access watchdog returns ERR to the owning master if the slave never acknowledges, so a hung slave cannot lock the bus.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT_CYCLES, 16, cycles an STB may wait for ACK before ERR is returned (must be >= 2)

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
m0_adr  input  ADDR_WIDTH  master 0 address
m0_dat_w  input  DATA_WIDTH  master 0 write data
m0_dat_r  output  DATA_WIDTH  master 0 read data
m0_sel  input  DATA_WIDTH/8  master 0 byte selects
m0_cyc  input  1  master 0 cycle
m0_stb  input  1  master 0 strobe
m0_we  input  1  master 0 write enable
m0_ack  output  1  master 0 acknowledge
m0_err  output  1  master 0 error (timeout)
m1_*  same set as m0_*  master 1
s_adr  output  ADDR_WIDTH  slave address
s_dat_w  output  DATA_WIDTH  slave write data
s_dat_r  input  DATA_WIDTH  slave read data
s_sel  output  DATA_WIDTH/8  slave byte selects
s_cyc  output  1  slave cycle
s_stb  output  1  slave strobe
s_we  output  1  slave write enable
s_ack  input  1  slave acknowledge
grant  output  2  one-hot current owner; 00 when idle
last_owner  output  1  index of most recently granted master

Behaviour:
- Reset (rstn=0 at posedge clk):
  - State IDLE, grant=00, last_owner=1 (so master 0 wins the first tie), watchdog=0.
  - All m*_ack/m*_err=0, s_cyc=s_stb=s_we=0.
- State IDLE:
  - Slave outputs are driven inactive: s_cyc/s_stb/s_we=0. s_adr/s_dat_w/s_sel=0.
  - If exactly one m*_cyc is high, grant that master.
  - If both are high, grant the master != last_owner.
  - The grant register is updated at the clock edge and the state moves to OWNED. Arbitration latency is 1 cycle from CYC to slave visibility.
- State OWNED:
  - The owner's adr/dat_w/sel/cyc/stb/we drive the slave combinationally.
  - s_ack drives owner m_ack combinationally. s_dat_r is fanned out to both m*_dat_r.
  - Non-owner ack/err are held 0, so its request stalls.
- Release: when owner cyc=0 at a clock edge, go to IDLE, grant=00, last_owner=owner index.
  - One IDLE cycle always separates consecutive owners, including back-to-back requests from the same master.
- Watchdog:
  - The counter increments each OWNED cycle with owner stb=1 and s_ack=0.
  - It clears on s_ack=1, on stb=0, or on leaving OWNED.
  - When the counter reaches TIMEOUT_CYCLES-1 with still no ACK, the next cycle is the error cycle:
    - owner m_err=1 for exactly 1 cycle, m_ack=0;
    - s_cyc/s_stb forced 0 that cycle;
    - counter clears.
  - The grant is retained. The master is expected to drop cyc.
  - If the master keeps stb asserted, the watchdog restarts.
- Simultaneous s_ack and timeout threshold: ACK wins, no ERR.
- m_ack and m_err are never both high.
- Owner dropping cyc in the same cycle as s_ack: the ack is passed through and release happens at that edge.
- Reset mid-transaction: all state returns to reset values at the next edge. The slave sees s_cyc=0 immediately after that edge.
- Arithmetic: watchdog width is $clog2(TIMEOUT_CYCLES)+1 and saturates (never wraps).

Test Plan:
- Single master: m0 writes 0xDEADBEEF to adr 0x10, then reads it back.
  - grant=01 one cycle after m0_cyc rises.
  - m0_dat_r=0xDEADBEEF on the read ack.
  - m1_ack stays 0 throughout.
- Contention: m0_cyc and m1_cyc rise on the same cycle after reset.
  - m0 is granted first.
  - After m0 drops cyc: one IDLE cycle (grant=00), then grant=10.
- Round-robin fairness: both masters hold cyc continuously, each doing single-access bursts for 8 bursts.
  - Grants alternate 01,10,01,10…
  - Each master completes 4 bursts; neither waits more than one burst.
- Burst hold: m1 owns the bus and issues 4 consecutive STB accesses with cyc held; m0 requests during the burst.
  - m0 is not granted until m1 drops cyc.
  - All 4 m1 accesses are acked.
- Timeout: slave model with ACK suppressed, TIMEOUT_CYCLES=16, m0 strobes.
  - m0_err=1 for exactly 1 cycle, 16 cycles after the first s_stb cycle.
  - s_stb=0 in that cycle.
  - After m0 drops cyc, m1 is granted normally.
- Reset mid-burst: rstn=0 while m1 owns the bus.
  - Next edge: grant=00, s_cyc=0, last_owner=1.
  - After rstn=1 with both masters requesting, m0 is granted first.
